// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with 2-bit saturating direction counters
module btb_predictor #(
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS = 22,
  parameter logic [1:0] CTR_INIT = 2'b10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_pc,
  input  logic                  stall,
  output logic                  bp_valid,
  output logic                  bp,
  output logic [31:0]           bp_addr,
  input  logic                  upd_valid,
  input  logic [31:0]           upd_pc,
  input  logic                  btb_web,
  input  logic [INDEX_BITS-1:0] btb_addr,
  input  logic [31:0]           btb_din,
  input  logic                  invalidate
);
  localparam int ENTRIES = 2**INDEX_BITS;
  logic [ENTRIES-1:0] valid;
  logic [TAG_BITS-1:0] tag_mem [ENTRIES];
  logic [31:0] tgt_mem [ENTRIES];
  logic [1:0] ctr_mem [ENTRIES];
  logic [INDEX_BITS-1:0] fidx, widx;
  logic [TAG_BITS-1:0] ftag, utag;
  logic hit, pred, taken, uhit, upd_on, alloc, tgt_we, ctr_we;
  logic [1:0] ctr_cur, ctr_nxt;
  logic unused;
  assign unused = ^{fetch_pc[1:0], upd_pc[1:0]};
  assign fidx = fetch_pc[INDEX_BITS+1:2];
  assign ftag = fetch_pc[31:INDEX_BITS+2];
  assign utag = upd_pc[31:INDEX_BITS+2];
  // Lookup reads the pre-edge table contents, so same-cycle writes are never bypassed.
  always_comb begin
    hit = valid[fidx] && tag_mem[fidx] == ftag;
    pred = hit && ctr_mem[fidx][1];
  end
  // Taken resolutions write at the FU-supplied index; an invalidate drops the whole update.
  always_comb begin
    taken = ~btb_web;
    widx = taken ? btb_addr : upd_pc[INDEX_BITS+1:2];
    uhit = valid[widx] && tag_mem[widx] == utag;
    ctr_cur = ctr_mem[widx];
    upd_on = upd_valid && !invalidate;
    alloc = upd_on && taken && !uhit;
    tgt_we = upd_on && taken;
    ctr_we = upd_on && (taken || uhit);
    ctr_nxt = !uhit ? CTR_INIT :
              taken ? (ctr_cur == 2'd3 ? 2'd3 : ctr_cur + 2'd1) :
              (ctr_cur == 2'd0 ? 2'd0 : ctr_cur - 2'd1);
  end
  // Valid bits and counters clear on reset; invalidate clears valids only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_mem[i] <= 2'd0;
    end else begin
      if (invalidate) valid <= '0;
      else if (alloc) valid[widx] <= 1'b1;
      if (ctr_we) ctr_mem[widx] <= ctr_nxt;
    end
  end
  // Tags and targets are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (alloc) tag_mem[widx] <= utag;
    if (tgt_we) tgt_mem[widx] <= btb_din;
  end
  // Registered prediction, frozen while fetch is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp_valid <= 1'b0;
      bp <= 1'b0;
      bp_addr <= 32'h0;
    end else if (!stall) begin
      bp_valid <= fetch_req;
      bp <= fetch_req && pred;
      bp_addr <= pred ? tgt_mem[fidx] : fetch_pc + 32'd4;
    end
  end
endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed self-checking bench for btb_predictor
module tb_btb_predictor;
  logic clk = 0;
  logic rst = 0;
  logic fetch_req = 0;
  logic [31:0] fetch_pc = 0;
  logic stall = 0;
  logic bp_valid, bp;
  logic [31:0] bp_addr;
  logic upd_valid = 0;
  logic [31:0] upd_pc = 0;
  logic btb_web = 1;
  logic [7:0] btb_addr = 0;
  logic [31:0] btb_din = 0;
  logic invalidate = 0;
  int checks = 0;
  int errors = 0;

  btb_predictor dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .stall(stall),
    .bp_valid(bp_valid), .bp(bp), .bp_addr(bp_addr), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .btb_web(btb_web), .btb_addr(btb_addr), .btb_din(btb_din), .invalidate(invalidate)
  );

  always #5 clk = ~clk;

  always @(posedge clk) assert (!(rst && !upd_valid && !btb_web)) else $error("btb_web low without upd_valid");

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] din);
    upd_valid = 1;
    upd_pc = pc;
    btb_web = !tk;
    btb_addr = pc[9:2];
    btb_din = din;
  endtask

  task automatic clr_upd();
    upd_valid = 0;
    btb_web = 1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] din);
    set_upd(pc, tk, din);
    @(negedge clk);
    clr_upd();
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    fetch_req = 1;
    fetch_pc = pc;
    @(negedge clk);
    fetch_req = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks += 3;
    if (bp_valid !== 1'b0) begin errors++; $display("FAIL reset_bp_valid got %b want 0", bp_valid); end
    if (bp !== 1'b0) begin errors++; $display("FAIL reset_bp got %b want 0", bp); end
    if (bp_addr !== 32'h0) begin errors++; $display("FAIL reset_bp_addr got %h want 0", bp_addr); end
    rst = 1;
    @(negedge clk);
    do_lookup(32'h1000);
    checks += 3;
    if (bp_valid !== 1'b1) begin errors++; $display("FAIL cold_bp_valid got %b want 1", bp_valid); end
    if (bp !== 1'b0) begin errors++; $display("FAIL cold_bp got %b want 0", bp); end
    if (bp_addr !== 32'h1004) begin errors++; $display("FAIL cold_bp_addr got %h want 00001004", bp_addr); end
  endtask

  task automatic test_allocate();
    upd(32'h1000, 1, 32'h2000);
    do_lookup(32'h1000);
    checks += 2;
    if (bp !== 1'b1) begin errors++; $display("FAIL alloc_bp got %b want 1", bp); end
    if (bp_addr !== 32'h2000) begin errors++; $display("FAIL alloc_bp_addr got %h want 00002000", bp_addr); end
  endtask

  task automatic test_counter();
    upd(32'h1000, 0, 0);
    upd(32'h1000, 0, 0);
    do_lookup(32'h1000);
    checks += 2;
    if (bp !== 1'b0) begin errors++; $display("FAIL ctr0_bp got %b want 0", bp); end
    if (bp_addr !== 32'h1004) begin errors++; $display("FAIL ctr0_bp_addr got %h want 00001004", bp_addr); end
    upd(32'h1000, 1, 32'h2000);
    do_lookup(32'h1000);
    checks++;
    if (bp !== 1'b0) begin errors++; $display("FAIL ctr1_bp got %b want 0", bp); end
    upd(32'h1000, 1, 32'h2000);
    do_lookup(32'h1000);
    checks += 2;
    if (bp !== 1'b1) begin errors++; $display("FAIL ctr2_bp got %b want 1", bp); end
    if (bp_addr !== 32'h2000) begin errors++; $display("FAIL ctr2_bp_addr got %h want 00002000", bp_addr); end
    for (int i = 0; i < 3; i++) upd(32'h1000, 1, 32'h2000);
    upd(32'h1000, 0, 0);
    do_lookup(32'h1000);
    checks++;
    if (bp !== 1'b1) begin errors++; $display("FAIL sat_hi_bp got %b want 1", bp); end
    for (int i = 0; i < 4; i++) upd(32'h1000, 0, 0);
    upd(32'h1000, 1, 32'h2000);
    do_lookup(32'h1000);
    checks++;
    if (bp !== 1'b0) begin errors++; $display("FAIL sat_lo_bp got %b want 0", bp); end
    upd(32'h1000, 1, 32'h2000);
    do_lookup(32'h1000);
    checks++;
    if (bp !== 1'b1) begin errors++; $display("FAIL retrain_bp got %b want 1", bp); end
  endtask

  task automatic test_alias();
    do_lookup(32'h1400);
    checks += 2;
    if (bp !== 1'b0) begin errors++; $display("FAIL alias_bp got %b want 0", bp); end
    if (bp_addr !== 32'h1404) begin errors++; $display("FAIL alias_bp_addr got %h want 00001404", bp_addr); end
    upd(32'h1400, 0, 0);
    do_lookup(32'h1000);
    checks++;
    if (bp !== 1'b1) begin errors++; $display("FAIL alias_nt_miss_bp got %b want 1", bp); end
  endtask

  task automatic test_same_cycle();
    fetch_req = 1;
    fetch_pc = 32'h3008;
    set_upd(32'h3008, 1, 32'h4000);
    @(negedge clk);
    fetch_req = 0;
    clr_upd();
    checks += 3;
    if (bp_valid !== 1'b1) begin errors++; $display("FAIL rbw_bp_valid got %b want 1", bp_valid); end
    if (bp !== 1'b0) begin errors++; $display("FAIL rbw_bp got %b want 0", bp); end
    if (bp_addr !== 32'h300c) begin errors++; $display("FAIL rbw_bp_addr got %h want 0000300c", bp_addr); end
    do_lookup(32'h3008);
    checks += 2;
    if (bp !== 1'b1) begin errors++; $display("FAIL rbw_next_bp got %b want 1", bp); end
    if (bp_addr !== 32'h4000) begin errors++; $display("FAIL rbw_next_bp_addr got %h want 00004000", bp_addr); end
  endtask

  task automatic test_stall();
    do_lookup(32'h3008);
    stall = 1;
    fetch_req = 1;
    for (int i = 0; i < 3; i++) begin
      fetch_pc = 32'h9000 + 32'(i * 4);
      @(negedge clk);
      checks += 3;
      if (bp_valid !== 1'b1) begin errors++; $display("FAIL stall_bp_valid cyc %0d got %b want 1", i, bp_valid); end
      if (bp !== 1'b1) begin errors++; $display("FAIL stall_bp cyc %0d got %b want 1", i, bp); end
      if (bp_addr !== 32'h4000) begin errors++; $display("FAIL stall_bp_addr cyc %0d got %h want 00004000", i, bp_addr); end
    end
    stall = 0;
    fetch_req = 0;
    @(negedge clk);
    checks++;
    if (bp_valid !== 1'b0) begin errors++; $display("FAIL unstall_bp_valid got %b want 0", bp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    logic exp_bp [3];
    logic [31:0] exp_addr [3];
    pcs = '{32'h1000, 32'h3008, 32'h5000};
    exp_bp = '{1'b1, 1'b1, 1'b0};
    exp_addr = '{32'h2000, 32'h4000, 32'h5004};
    fetch_req = 1;
    for (int i = 0; i < 3; i++) begin
      fetch_pc = pcs[i];
      @(negedge clk);
      checks += 2;
      if (bp !== exp_bp[i]) begin errors++; $display("FAIL b2b_bp[%0d] got %b want %b", i, bp, exp_bp[i]); end
      if (bp_addr !== exp_addr[i]) begin errors++; $display("FAIL b2b_bp_addr[%0d] got %h want %h", i, bp_addr, exp_addr[i]); end
    end
    fetch_req = 0;
  endtask

  task automatic test_invalidate();
    invalidate = 1;
    fetch_req = 1;
    fetch_pc = 32'h1000;
    set_upd(32'h5000, 1, 32'h6000);
    @(negedge clk);
    invalidate = 0;
    fetch_req = 0;
    clr_upd();
    checks += 2;
    if (bp !== 1'b1) begin errors++; $display("FAIL inv_same_bp got %b want 1", bp); end
    if (bp_addr !== 32'h2000) begin errors++; $display("FAIL inv_same_bp_addr got %h want 00002000", bp_addr); end
    do_lookup(32'h1000);
    checks += 2;
    if (bp !== 1'b0) begin errors++; $display("FAIL inv_1000_bp got %b want 0", bp); end
    if (bp_addr !== 32'h1004) begin errors++; $display("FAIL inv_1000_bp_addr got %h want 00001004", bp_addr); end
    do_lookup(32'h3008);
    checks++;
    if (bp !== 1'b0) begin errors++; $display("FAIL inv_3008_bp got %b want 0", bp); end
    do_lookup(32'h5000);
    checks += 2;
    if (bp !== 1'b0) begin errors++; $display("FAIL inv_5000_bp got %b want 0", bp); end
    if (bp_addr !== 32'h5004) begin errors++; $display("FAIL inv_5000_bp_addr got %h want 00005004", bp_addr); end
  endtask

  task automatic test_async_reset();
    upd(32'h1000, 1, 32'h2000);
    do_lookup(32'h1000);
    checks++;
    if (bp !== 1'b1) begin errors++; $display("FAIL prerst_bp got %b want 1", bp); end
    fetch_req = 1;
    #2;
    rst = 0;
    #1;
    checks += 3;
    if (bp_valid !== 1'b0) begin errors++; $display("FAIL arst_bp_valid got %b want 0", bp_valid); end
    if (bp !== 1'b0) begin errors++; $display("FAIL arst_bp got %b want 0", bp); end
    if (bp_addr !== 32'h0) begin errors++; $display("FAIL arst_bp_addr got %h want 0", bp_addr); end
    fetch_req = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    do_lookup(32'h1000);
    checks += 2;
    if (bp !== 1'b0) begin errors++; $display("FAIL postrst_bp got %b want 0", bp); end
    if (bp_addr !== 32'h1004) begin errors++; $display("FAIL postrst_bp_addr got %h want 00001004", bp_addr); end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_same_cycle();
    test_stall();
    test_back_to_back();
    test_invalidate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Branch target buffer with 2-bit saturating direction counters.
- Sits upstream of the branch functional unit and is written by it:
  - Fetch looks up the PC each cycle.
  - The registered prediction (bp, bp_addr) travels with the instruction through decode into decode_info.
  - The branch FU's resolution (btb_web/btb_addr/btb_din plus upd_* sideband) trains the table.
- Storage is flop-based so that asynchronous reset clears every entry.

Parameters:
- INDEX_BITS, 8, table index width; ENTRIES = 2**INDEX_BITS; index = pc[INDEX_BITS+1:2].
- TAG_BITS, 22, tag width; tag = pc[31:INDEX_BITS+2]; must equal 30-INDEX_BITS.
- CTR_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- fetch_req  in  1  lookup request for fetch_pc this cycle.
- fetch_pc  in  32  PC being fetched.
- stall  in  1  fetch stalled; hold all prediction outputs.
- bp_valid  out  1  registered; bp/bp_addr correspond to the PC requested one cycle earlier.
- bp  out  1  registered predicted-taken.
- bp_addr  out  32  registered predicted next PC.
- upd_valid  in  1  a branch/jump resolved this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- btb_web  in  1  active-low; 0 = resolved taken, write target.
- btb_addr  in  INDEX_BITS  write index; must equal upd_pc index when btb_web=0.
- btb_din  in  32  resolved taken target.
- invalidate  in  1  clear all valid bits (fence.i / context change).

Behaviour:
- Entry fields: valid, tag[TAG_BITS], target[32], ctr[2].
- Reset (rst=0, async):
  - All entries: valid=0, ctr=0.
  - bp_valid=0, bp=0, bp_addr=32'h0.
  - Takes effect mid-operation immediately; pending lookups are discarded.
- Lookup (combinational read, registered result, latency 1):
  - hit = entry[idx].valid && entry[idx].tag == fetch_pc tag.
  - pred = hit && ctr[1].
  - At the edge, when stall=0:
    - bp_valid <= fetch_req.
    - bp <= fetch_req && pred.
    - bp_addr <= pred ? target : fetch_pc+4 (32-bit wrap).
  - When stall=1, all three outputs hold their values and no lookup is latched.
- Update, when upd_valid=1:
  - taken = ~btb_web.
  - upd_hit = valid && tag match for upd_pc at its index.
  - Taken, upd_hit: ctr saturating increment (max 3); target <= btb_din.
  - Taken, miss: allocate/overwrite the entry: valid=1, tag=upd_pc tag, target=btb_din, ctr=CTR_INIT.
  - Not taken, upd_hit: ctr saturating decrement (min 0); target unchanged.
  - Not taken, miss: no change.
  - btb_web=0 with upd_valid=0 is ignored; the bench asserts it never occurs.
- Simultaneous lookup and update to the same index: the lookup uses pre-update contents (read-before-write, no bypass).
- invalidate=1:
  - All valid <= 0 at the edge; ctr and target are left as is.
  - Beats a same-cycle update (the update is dropped).
  - A lookup latched in the same cycle still uses pre-invalidate contents.
- Index aliasing: a tag mismatch is a miss, so the prediction is not-taken with bp_addr = fetch_pc+4.
- No other state machine; throughput is one lookup and one update per cycle.

Test Plan:
- Reset then lookup 0x0000_1000 -> next cycle bp_valid=1, bp=0, bp_addr=0x0000_1004.
- Taken update upd_pc=0x0000_1000, btb_addr=0x00, btb_din=0x0000_2000, then lookup 0x0000_1000 -> bp=1, bp_addr=0x0000_2000 (ctr=2).
- Counter training on that entry:
  - Two not-taken updates -> ctr 2→1→0; lookup gives bp=0.
  - One taken update -> ctr=1, still bp=0.
  - A second taken update -> ctr=2, bp=1.
  - Increments saturate at 3, decrements at 0.
- Alias: entry allocated for 0x0000_1000, lookup 0x0000_1400 (same index 0x00, different tag) -> bp=0, bp_addr=0x0000_1404.
- Same-cycle lookup and taken allocate of 0x0000_3008 -> that cycle's result bp=0; the following lookup gives bp=1.
- Stall held 3 cycles with changing fetch_pc -> outputs constant.
- Invalidate concurrent with a taken update -> all subsequent lookups miss.
- Assert rst=0 mid-stream asynchronously -> outputs 0 before the next edge.
